// File: rtl/unsigned_prod_accum.sv
// unsigned_prod_accum
//
// Purpose:
//   Sums groups of 16-bit unsigned product terms from an upstream 8x8
//   multiplier. A group closes after LEN accepted terms, or earlier on a
//   term flagged with in_last. The group sum is registered, together with
//   an overflow flag, and held until the downstream consumer takes it.
//   A term accepted in the same cycle as an output handshake starts the
//   next group, so back-to-back groups run without a bubble.
//
// Parameters:
//   LEN    number of terms per group (1..256)
//   ACC_W  accumulator / result width (16..32)
//
// Configuration macro:
//   UNSIGNED_PROD_ACCUM_SAT_EN  when defined, the accumulator and the result
//                               clamp to 2^ACC_W-1 once any carry occurs in
//                               a group; otherwise sums wrap modulo 2^ACC_W.
//                               out_ovf reports the overflow in both builds.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   in_z holds a valid term
//   in_z       16-bit unsigned term
//   in_last    accepted term closes the current group
//   in_ready   combinational: a term is accepted this cycle if in_valid
//   out_valid  out_sum / out_ovf hold a completed group result
//   out_ready  consumer takes the result this cycle
//   out_sum    group sum (ACC_W bits)
//   out_ovf    group sum exceeded 2^ACC_W-1

module unsigned_prod_accum #(
    parameter int unsigned LEN   = 16,
    parameter int unsigned ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [15:0]      in_z,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);

    localparam int unsigned   CNT_W    = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int unsigned   SUM_W    = ACC_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = '1;

    // Running group state
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    // Next-state values
    logic [ACC_W-1:0] acc_d;
    logic [CNT_W-1:0] cnt_d;
    logic             ovf_d;
    logic             out_valid_d;
    logic [ACC_W-1:0] out_sum_d;
    logic             out_ovf_d;

    // Datapath
    logic             accept;
    logic             closing;
    logic [SUM_W-1:0] sum_ext;
    logic             carry;
    logic [ACC_W-1:0] add_res;

    // The result slot is free when empty or being drained this cycle
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // With LEN==1 the counter is stuck at 0 == CNT_LAST, so every term closes
    assign closing  = (cnt == CNT_LAST) || in_last;

    // One extra bit catches the carry out of the accumulator
    assign sum_ext  = SUM_W'(acc) + SUM_W'(in_z);
    assign carry    = sum_ext[ACC_W];

`ifdef UNSIGNED_PROD_ACCUM_SAT_EN
    // Once the group has overflowed it stays pinned at full scale
    assign add_res  = (carry || ovf) ? ACC_MAX : sum_ext[ACC_W-1:0];
`else
    // Modulo 2^ACC_W wrap; overflow is only reported through ovf
    assign add_res  = sum_ext[ACC_W-1:0];
`endif

    // Next-state logic
    always_comb begin
        acc_d       = acc;
        cnt_d       = cnt;
        ovf_d       = ovf;
        out_valid_d = out_valid;
        out_sum_d   = out_sum;
        out_ovf_d   = out_ovf;

        if (out_valid && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (closing) begin
                // A closing accept overrides the drain above: new result loads
                out_valid_d = 1'b1;
                out_sum_d   = add_res;
                out_ovf_d   = ovf || carry;
                acc_d       = '0;
                cnt_d       = '0;
                ovf_d       = 1'b0;
            end else begin
                acc_d       = add_res;
                cnt_d       = cnt + CNT_W'(1);
                ovf_d       = ovf || carry;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            acc       <= acc_d;
            cnt       <= cnt_d;
            ovf       <= ovf_d;
            out_valid <= out_valid_d;
            out_sum   <= out_sum_d;
            out_ovf   <= out_ovf_d;
        end
    end

endmodule
